// File: rtl/ofdm_result_tx.sv
`default_nettype none
// ============================================================================
// Module   : ofdm_result_tx
// Purpose  : Serialises one OFDM demodulation result (96-bit payload plus a
//            success flag) into a framed byte stream for the shared uart_tx
//            byte interface. One start pulse in, one frame out, one done
//            pulse back.
//
//            Default build : 15-byte binary frame
//                            SYNC, STATUS, res[95:88] .. res[7:0], CSUM
//            OFDM_RESULT_HEX_EN defined : 29-byte ASCII frame
//                            'S'/'F', 24 hex chars of res, 2 hex chars of
//                            CSUM, CR, LF (SYNC_BYTE unused)
//            CSUM is the 8-bit wrap-around sum of STATUS (8'h01/8'h00) and
//            the 12 raw res bytes in both builds.
//
// Ports    : clk            system clock
//            rst_n          asynchronous reset, active low
//            start          1-cycle pulse: capture res/success, send frame
//            success        OFDM sync/decode success flag
//            res[95:0]      OFDM result, res[95:88] sent first
//            busy           high from capture until done
//            done           1-cycle pulse: frame finished or aborted
//            timeout_err    sticky byte-timeout flag, cleared by next start
//            uart_tx_start  1-cycle pulse per byte to uart_tx
//            uart_tx_data   byte for uart_tx, held until the next byte
//            uart_tx_finish from uart_tx; byte complete on its rising edge
//
// Revision : 1.0  initial release
// ============================================================================
module ofdm_result_tx #(
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         TX_TIMEOUT = 10000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        success,
  input  logic [95:0] res,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic        uart_tx_start,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_finish
);

  // Wait counter is at least 14 bits and always wide enough to hold
  // TX_TIMEOUT, so it can never wrap before the timeout fires.
  localparam int c_CNT_W = ($clog2(TX_TIMEOUT + 1) > 14) ? $clog2(TX_TIMEOUT + 1) : 14;
  localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TX_TIMEOUT);

`ifdef OFDM_RESULT_HEX_EN
  localparam logic [4:0] c_LAST_IDX = 5'd28;
`else
  localparam logic [4:0] c_LAST_IDX = 5'd14;
`endif

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_LOAD = 3'd1;
  localparam logic [2:0] c_SEND = 3'd2;
  localparam logic [2:0] c_WAIT = 3'd3;
  localparam logic [2:0] c_FIN  = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_state_next;
  logic [95:0]        r_res;
  logic               r_success;
  logic [4:0]         r_index;
  logic [7:0]         r_csum;
  logic [c_CNT_W-1:0] r_wait_cnt;
  logic               r_finish_prev;
  logic               r_busy;
  logic               r_done;
  logic               r_timeout_err;
  logic               r_uart_start;
  logic [7:0]         r_uart_data;

  logic               w_finish_rise;
  logic               w_timed_out;
  logic               w_capture;
  logic               w_load;
  logic               w_send;
  logic               w_wait;
  logic               w_advance;
  logic               w_timeout;
  logic               w_fin;
  logic [7:0]         w_status;
  logic [7:0]         w_byte;
  logic [7:0]         w_csum_term;
  logic               w_csum_add;

  assign w_finish_rise = uart_tx_finish & ~r_finish_prev;
  assign w_timed_out   = (r_wait_cnt >= c_TIMEOUT);
  assign w_status      = {7'd0, r_success};

  // Captured payload split into bytes, MSB byte first. The table is padded
  // to 32 entries so a full 5-bit index can address it directly.
  logic [7:0] w_res_byte [32];
  generate
    for (genvar g = 0; g < 32; g++) begin : g_res_byte
      if (g < 12) begin : g_used
        assign w_res_byte[g] = r_res[95 - 8*g -: 8];
      end else begin : g_pad
        assign w_res_byte[g] = 8'h00;
      end
    end
  endgenerate

`ifdef OFDM_RESULT_HEX_EN
  logic [3:0] w_res_nib [32];
  generate
    for (genvar g = 0; g < 32; g++) begin : g_res_nib
      if (g < 24) begin : g_used
        assign w_res_nib[g] = r_res[95 - 4*g -: 4];
      end else begin : g_pad
        assign w_res_nib[g] = 4'h0;
      end
    end
  endgenerate

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    hex_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  // Byte at the current index. The checksum covers the raw STATUS and res
  // bytes, so a res byte is added once its second hex character goes out
  // (even indices 2..24).
  always_comb begin
    w_byte      = 8'h00;
    w_csum_term = 8'h00;
    w_csum_add  = 1'b0;
    if (r_index == 5'd0) begin
      w_byte      = r_success ? 8'h53 : 8'h46;
      w_csum_term = w_status;
      w_csum_add  = 1'b1;
    end else if (r_index <= 5'd24) begin
      w_byte = hex_char(w_res_nib[r_index - 5'd1]);
      if (!r_index[0]) begin
        w_csum_term = w_res_byte[(r_index >> 1) - 5'd1];
        w_csum_add  = 1'b1;
      end
    end else if (r_index == 5'd25) begin
      w_byte = hex_char(r_csum[7:4]);
    end else if (r_index == 5'd26) begin
      w_byte = hex_char(r_csum[3:0]);
    end else if (r_index == 5'd27) begin
      w_byte = 8'h0D;
    end else begin
      w_byte = 8'h0A;
    end
  end
`else
  // Byte at the current index; SYNC and CSUM itself are not summed.
  always_comb begin
    w_byte      = 8'h00;
    w_csum_term = 8'h00;
    w_csum_add  = 1'b0;
    if (r_index == 5'd0) begin
      w_byte = SYNC_BYTE;
    end else if (r_index == 5'd1) begin
      w_byte      = w_status;
      w_csum_term = w_status;
      w_csum_add  = 1'b1;
    end else if (r_index <= 5'd13) begin
      w_byte      = w_res_byte[r_index - 5'd2];
      w_csum_term = w_res_byte[r_index - 5'd2];
      w_csum_add  = 1'b1;
    end else begin
      w_byte = r_csum;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic. A finish edge takes priority over a timeout that
  // expires in the same cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE: if (start) w_state_next = c_LOAD;
      c_LOAD: w_state_next = c_SEND;
      c_SEND: w_state_next = c_WAIT;
      c_WAIT: begin
        if (w_finish_rise) begin
          w_state_next = (r_index == c_LAST_IDX) ? c_FIN : c_SEND;
        end else if (w_timed_out) begin
          w_state_next = c_FIN;
        end
      end
      c_FIN:   w_state_next = c_IDLE;
      default: w_state_next = c_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output decode (controls for the registered datapath below)
  // --------------------------------------------------------------------------
  always_comb begin
    w_capture = (r_state == c_IDLE) && start;
    w_load    = (r_state == c_LOAD);
    w_send    = (r_state == c_SEND);
    w_wait    = (r_state == c_WAIT);
    w_advance = w_wait && w_finish_rise;
    w_timeout = w_wait && !w_finish_rise && w_timed_out;
    w_fin     = (r_state == c_FIN);
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res         <= 96'd0;
      r_success     <= 1'b0;
      r_index       <= 5'd0;
      r_csum        <= 8'd0;
      r_wait_cnt    <= '0;
      r_finish_prev <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_uart_start  <= 1'b0;
      r_uart_data   <= 8'd0;
    end else begin
      // Edge detector runs in every state so a stale high level on
      // uart_tx_finish never looks like a fresh edge once WAIT is entered.
      r_finish_prev <= uart_tx_finish;
      r_uart_start  <= w_send;
      r_done        <= w_fin;

      if (w_capture) begin
        r_res         <= res;
        r_success     <= success;
        r_timeout_err <= 1'b0;
        r_busy        <= 1'b1;
      end

      if (w_load) begin
        r_index <= 5'd0;
        r_csum  <= 8'd0;
      end

      if (w_send) begin
        r_uart_data <= w_byte;
        r_wait_cnt  <= '0;
        if (w_csum_add) begin
          r_csum <= r_csum + w_csum_term;
        end
      end

      if (w_wait) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end

      if (w_advance) begin
        r_index <= r_index + 5'd1;
      end

      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end

      if (w_fin) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign timeout_err   = r_timeout_err;
  assign uart_tx_start = r_uart_start;
  assign uart_tx_data  = r_uart_data;

endmodule
`default_nettype wire

// File: tb/tb_ofdm_result_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofdm_result_tx
// Purpose  : Self-checking bench for ofdm_result_tx. A responder models the
//            uart_tx byte interface (finish pulse a few cycles after each
//            start, optionally withheld), and a frame model built from the
//            frame rules produces the expected byte sequence.
// Revision : 1.0  initial release
// ============================================================================
module tb_ofdm_result_tx;

  localparam int c_TIMEOUT = 400;
  localparam int c_MAX_CYC = 3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        success = 1'b0;
  logic [95:0] res = 96'd0;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic        uart_tx_start;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_finish = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Responder / monitor state (written only by the responder process)
  logic [7:0] mon_q [$];
  int         done_count = 0;
  int         done_cyc = 0;
  int         last_start_cyc = 0;
  int         fin_cnt = 0;
  int         cyc = 0;

  // Responder controls and frame bookkeeping (written only by the test process)
  int         ack_limit = -1;
  bit         rand_delay = 1'b0;
  int         base_q = 0;
  int         base_done = 0;
  logic [7:0] exp_q [$];

  ofdm_result_tx #(
    .SYNC_BYTE  (8'hA5),
    .TX_TIMEOUT (c_TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .success        (success),
    .res            (res),
    .busy           (busy),
    .done           (done),
    .timeout_err    (timeout_err),
    .uart_tx_start  (uart_tx_start),
    .uart_tx_data   (uart_tx_data),
    .uart_tx_finish (uart_tx_finish)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx model: records every byte handed over and answers with a
  // one-cycle finish pulse, unless the acknowledge limit has been reached.
  always @(negedge clk) begin
    uart_tx_finish = 1'b0;
    if (!rst_n) begin
      fin_cnt = 0;
    end else begin
      if (fin_cnt > 0) begin
        fin_cnt--;
        if (fin_cnt == 0) uart_tx_finish = 1'b1;
      end
      if (uart_tx_start) begin
        mon_q.push_back(uart_tx_data);
        last_start_cyc = cyc;
        if (ack_limit < 0 || mon_q.size() <= ack_limit)
          fin_cnt = rand_delay ? int'($urandom_range(1, 6)) : 3;
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #(80000 * 10);
    $display("FAIL watchdog: simulation did not finish, time=%0t required below limit", $time);
    $fatal(1);
  end

  function automatic logic [7:0] hexc(input int n);
    string hs;
    hs = "0123456789ABCDEF";
    return hs[n];
  endfunction

  // Expected frame straight from the framing rules.
  task automatic build_expected(input logic [95:0] r, input logic s);
    logic [7:0] b [12];
    int         sum;
    logic [7:0] cs;
    sum = s ? 1 : 0;
    for (int i = 0; i < 12; i++) begin
      b[i] = r[95 - 8*i -: 8];
      sum += int'(b[i]);
    end
    cs = 8'(sum % 256);
    exp_q.delete();
`ifdef OFDM_RESULT_HEX_EN
    exp_q.push_back(s ? 8'h53 : 8'h46);
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(hexc(int'(b[i][7:4])));
      exp_q.push_back(hexc(int'(b[i][3:0])));
    end
    exp_q.push_back(hexc(int'(cs[7:4])));
    exp_q.push_back(hexc(int'(cs[3:0])));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`else
    exp_q.push_back(8'hA5);
    exp_q.push_back(s ? 8'h01 : 8'h00);
    for (int i = 0; i < 12; i++) exp_q.push_back(b[i]);
    exp_q.push_back(cs);
`endif
  endtask

  function automatic logic [95:0] rand96();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Stimulus: pulse start, scramble inputs after capture, optionally pulse a
  // second start once `intrude_at` bytes have gone out, wait for done.
  task automatic run_frame(input logic [95:0] r, input logic s, input int intrude_at, output bit ok);
    bit intruded;
    base_q    = mon_q.size();
    base_done = done_count;
    build_expected(r, s);
    res = r;
    success = s;
    start = 1'b1;
    ok = 1'b0;
    intruded = 1'b0;
    for (int n = 0; n < c_MAX_CYC; n++) begin
      @(negedge clk); #1;
      start = 1'b0;
      if (n == 0) begin
        res = rand96();
        success = ~s;
      end
      if (done_count > base_done) begin
        ok = 1'b1;
        break;
      end
      if (intrude_at >= 0 && !intruded && mon_q.size() >= base_q + intrude_at) begin
        start = 1'b1;
        res = rand96();
        intruded = 1'b1;
      end
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_terr: got %b want 0", timeout_err); end
    n_checks++; if (uart_tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_txstart: got %b want 0", uart_tx_start); end
    n_checks++; if (uart_tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_txdata: got %h want 00", uart_tx_data); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic test_latency();
    int lat;
    bit seen_done;
    base_done = done_count;
    res = 96'h0102_0304_0506_0708_090A_0B0C;
    success = 1'b1;
    start = 1'b1;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); #1;
      start = 1'b0;
      if (uart_tx_start === 1'b1) begin
        lat = i;
        break;
      end
    end
    // first sampling point after the capture edge is i=1, so N+2 shows at i=3
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL latency: got %0d want 3", lat); end
`ifdef OFDM_RESULT_HEX_EN
    n_checks++; if (uart_tx_data !== 8'h53) begin n_fail++; $display("FAIL first_byte: got %h want 53", uart_tx_data); end
`else
    n_checks++; if (uart_tx_data !== 8'hA5) begin n_fail++; $display("FAIL first_byte: got %h want a5", uart_tx_data); end
`endif
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_frame: got %b want 1", busy); end
    seen_done = 1'b0;
    for (int n = 0; n < c_MAX_CYC; n++) begin
      @(negedge clk); #1;
      if (done_count > base_done) begin seen_done = 1'b1; break; end
    end
    n_checks++; if (!seen_done) begin n_fail++; $display("FAIL latency_done: got no done want done"); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_done: got %b want 0", busy); end
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [95:0] vr [3];
    logic        vs [3];
    bit          ok;
    vr[0] = 96'h0102_0304_0506_0708_090A_0B0C; vs[0] = 1'b1;
    vr[1] = {12{8'hFF}};                        vs[1] = 1'b0;
    vr[2] = 96'h0123_4567_89AB_CDEF_0011_2233; vs[2] = 1'b1;
    rand_delay = 1'b0;
    ack_limit = -1;
    for (int v = 0; v < 3; v++) begin
      run_frame(vr[v], vs[v], -1, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL dir%0d_done_seen: got none want done", v); end
      n_checks++; if (mon_q.size() - base_q != exp_q.size()) begin n_fail++; $display("FAIL dir%0d_len: got %0d want %0d", v, mon_q.size() - base_q, exp_q.size()); end
      for (int i = 0; i < exp_q.size() && base_q + i < mon_q.size(); i++) begin
        n_checks++;
        if (mon_q[base_q + i] !== exp_q[i]) begin n_fail++; $display("FAIL dir%0d_byte%0d: got %h want %h", v, i, mon_q[base_q + i], exp_q[i]); end
      end
      n_checks++; if (done_count - base_done != 1) begin n_fail++; $display("FAIL dir%0d_done_count: got %0d want 1", v, done_count - base_done); end
      n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL dir%0d_terr: got %b want 0", v, timeout_err); end
    end
  endtask

  task automatic test_random();
    bit ok;
    rand_delay = 1'b1;
    ack_limit = -1;
    for (int v = 0; v < 6; v++) begin
      run_frame(rand96(), 1'($urandom_range(0, 1)), -1, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rnd%0d_done_seen: got none want done", v); end
      n_checks++; if (mon_q.size() - base_q != exp_q.size()) begin n_fail++; $display("FAIL rnd%0d_len: got %0d want %0d", v, mon_q.size() - base_q, exp_q.size()); end
      for (int i = 0; i < exp_q.size() && base_q + i < mon_q.size(); i++) begin
        n_checks++;
        if (mon_q[base_q + i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd%0d_byte%0d: got %h want %h", v, i, mon_q[base_q + i], exp_q[i]); end
      end
      n_checks++; if (done_count - base_done != 1) begin n_fail++; $display("FAIL rnd%0d_done_count: got %0d want 1", v, done_count - base_done); end
    end
    rand_delay = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok;
    int gap;
    rand_delay = 1'b0;
    ack_limit = mon_q.size() + 2;   // acknowledge two bytes, let the third hang
    run_frame(rand96(), 1'b1, -1, ok);
    ack_limit = -1;
    gap = done_cyc - last_start_cyc;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL to_done_seen: got none want done"); end
    n_checks++; if (mon_q.size() - base_q != 3) begin n_fail++; $display("FAIL to_pulses: got %0d want 3", mon_q.size() - base_q); end
    for (int i = 0; i < 3 && base_q + i < mon_q.size(); i++) begin
      n_checks++;
      if (mon_q[base_q + i] !== exp_q[i]) begin n_fail++; $display("FAIL to_byte%0d: got %h want %h", i, mon_q[base_q + i], exp_q[i]); end
    end
    n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_terr: got %b want 1", timeout_err); end
    n_checks++; if (gap < c_TIMEOUT || gap > c_TIMEOUT + 3) begin n_fail++; $display("FAIL to_gap: got %0d want %0d..%0d", gap, c_TIMEOUT, c_TIMEOUT + 3); end
    n_checks++; if (done_count - base_done != 1) begin n_fail++; $display("FAIL to_done_count: got %0d want 1", done_count - base_done); end
    // still sticky while idle
    repeat (5) @(negedge clk);
    #1;
    n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
    // the next accepted start clears it and a full frame follows
    run_frame(rand96(), 1'b0, -1, ok);
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_cleared: got %b want 0", timeout_err); end
    n_checks++; if (mon_q.size() - base_q != exp_q.size()) begin n_fail++; $display("FAIL to_recover_len: got %0d want %0d", mon_q.size() - base_q, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && base_q + i < mon_q.size(); i++) begin
      n_checks++;
      if (mon_q[base_q + i] !== exp_q[i]) begin n_fail++; $display("FAIL to_recover_byte%0d: got %h want %h", i, mon_q[base_q + i], exp_q[i]); end
    end
  endtask

  task automatic test_start_while_busy();
    bit ok;
    rand_delay = 1'b1;
    run_frame(rand96(), 1'b1, 5, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL busy_done_seen: got none want done"); end
    n_checks++; if (mon_q.size() - base_q != exp_q.size()) begin n_fail++; $display("FAIL busy_len: got %0d want %0d", mon_q.size() - base_q, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && base_q + i < mon_q.size(); i++) begin
      n_checks++;
      if (mon_q[base_q + i] !== exp_q[i]) begin n_fail++; $display("FAIL busy_byte%0d: got %h want %h", i, mon_q[base_q + i], exp_q[i]); end
    end
    n_checks++; if (done_count - base_done != 1) begin n_fail++; $display("FAIL busy_done_count: got %0d want 1", done_count - base_done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_idle: got %b want 0", busy); end
    rand_delay = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    bit reached;
    base_q = mon_q.size();
    res = 96'h0102_0304_0506_0708_090A_0B0C;
    success = 1'b1;
    start = 1'b1;
    reached = 1'b0;
    for (int n = 0; n < c_MAX_CYC; n++) begin
      @(negedge clk); #1;
      start = 1'b0;
      if (mon_q.size() >= base_q + 7) begin reached = 1'b1; break; end
    end
    n_checks++; if (!reached) begin n_fail++; $display("FAIL rst_mid_reach: got %0d bytes want 7", mon_q.size() - base_q); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    n_checks++; if (uart_tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_txdata: got %h want 00", uart_tx_data); end
    n_checks++; if (uart_tx_start !== 1'b0) begin n_fail++; $display("FAIL rst_mid_txstart: got %b want 0", uart_tx_start); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b want 0", done); end
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    n_checks++; if (mon_q.size() - base_q != 7) begin n_fail++; $display("FAIL rst_mid_no_resume: got %0d bytes want 7", mon_q.size() - base_q); end
    run_frame(rand96(), 1'($urandom_range(0, 1)), -1, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_new_done_seen: got none want done"); end
    n_checks++; if (mon_q.size() - base_q != exp_q.size()) begin n_fail++; $display("FAIL rst_new_len: got %0d want %0d", mon_q.size() - base_q, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && base_q + i < mon_q.size(); i++) begin
      n_checks++;
      if (mon_q[base_q + i] !== exp_q[i]) begin n_fail++; $display("FAIL rst_new_byte%0d: got %h want %h", i, mon_q[base_q + i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_random();
    test_timeout();
    test_start_while_busy();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
